// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU memory bus: state encoding, requester IDs and bus widths.
package cpu_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WAIT   = 2'b10,
    DONE   = 2'b11
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_MON = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
// master is the arbiter's view, slave is the view of requesters plus memory.
interface mem_bus_arbiter_if;
  import cpu_bus_pkg::*;

  logic  cpu_req;
  logic  cpu_we;
  addr_t cpu_addr;
  data_t cpu_wdata;
  logic  cpu_gnt;
  logic  cpu_done;
  data_t cpu_rdata;

  logic  mon_req;
  logic  mon_we;
  addr_t mon_addr;
  data_t mon_wdata;
  logic  mon_gnt;
  logic  mon_done;
  data_t mon_rdata;

  logic  mem_en;
  logic  mem_we;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_rdata;

  logic  busy;
  logic  owner;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mon_req, mon_we, mon_addr, mon_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    output mon_gnt, mon_done, mon_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, owner
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mon_req, mon_we, mon_addr, mon_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    input  mon_gnt, mon_done, mon_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, owner
  );

endinterface

// File: rtl/starve_timer.sv
// Saturating wait counter for a low-priority requester; limit_hit flags that it
// has been denied LIMIT consecutive cycles and must win the next arbitration.
module starve_timer #(
  parameter int LIMIT = 8,
  parameter int WIDTH = 8
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic inc,
  input  logic clear,
  output logic limit_hit
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != LIMIT_V)) begin
      count <= count + 1'b1;
    end
  end

  assign limit_hit = (count == LIMIT_V);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority arbiter sharing one memory port between the CPU and the debug
// monitor, sequencing each access IDLE -> ACCESS -> (WAIT) -> DONE.
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int MEM_LATENCY  = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_in,
  input  logic              reset_n,
  mem_bus_arbiter_if.master bus
);

  localparam logic [1:0] WAIT_LOAD = (MEM_LATENCY > 0) ? 2'(MEM_LATENCY - 1) : 2'd0;

  arb_state_t state, state_next;
  logic [1:0] wait_cnt, wait_cnt_next;
  logic       any_req, mon_wins, mon_starved;
  logic       latch, sample;
  logic       cpu_gnt_next, mon_gnt_next, cpu_done_next, mon_done_next;
  logic       starve_inc, starve_clear;

  assign any_req      = bus.cpu_req | bus.mon_req;
  assign mon_wins     = bus.mon_req & (~bus.cpu_req | mon_starved);
  // The monitor only ages while it is waiting, not while its own access is in flight.
  assign starve_inc   = bus.mon_req & ~(bus.busy & (bus.owner == REQ_MON));
  assign starve_clear = ~bus.mon_req | (latch & mon_wins);

  starve_timer #(
    .LIMIT (STARVE_LIMIT),
    .WIDTH (8)
  ) u_starve (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .inc       (starve_inc),
    .clear     (starve_clear),
    .limit_hit (mon_starved)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    latch         = 1'b0;
    sample        = 1'b0;
    cpu_gnt_next  = 1'b0;
    mon_gnt_next  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next   = ACCESS;
          latch        = 1'b1;
          cpu_gnt_next = ~mon_wins;
          mon_gnt_next = mon_wins;
        end
      end
      ACCESS: begin
        if (MEM_LATENCY == 0) begin
          state_next = DONE;
          sample     = 1'b1;
        end else begin
          state_next    = WAIT;
          wait_cnt_next = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (wait_cnt == 2'd0) begin
          state_next = DONE;
          sample     = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt - 2'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    cpu_done_next = sample & (bus.owner == REQ_CPU);
    mon_done_next = sample & (bus.owner == REQ_MON);
  end

  // Every output is a flop so nothing combinational leaks from the requesters.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      bus.cpu_gnt   <= 1'b0;
      bus.mon_gnt   <= 1'b0;
      bus.cpu_done  <= 1'b0;
      bus.mon_done  <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.mon_rdata <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
      bus.owner     <= REQ_CPU;
    end else begin
      bus.cpu_gnt  <= cpu_gnt_next;
      bus.mon_gnt  <= mon_gnt_next;
      bus.cpu_done <= cpu_done_next;
      bus.mon_done <= mon_done_next;
      bus.mem_en   <= latch;
      bus.busy     <= (state_next != IDLE);
      if (latch) begin
        bus.owner     <= mon_wins ? REQ_MON : REQ_CPU;
        bus.mem_we    <= mon_wins ? bus.mon_we : bus.cpu_we;
        bus.mem_addr  <= mon_wins ? bus.mon_addr : bus.cpu_addr;
        bus.mem_wdata <= mon_wins ? bus.mon_wdata : bus.cpu_wdata;
      end
      if (sample && !bus.mem_we) begin
        if (bus.owner == REQ_MON) begin
          bus.mon_rdata <= bus.mem_rdata;
        end else begin
          bus.cpu_rdata <= bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single 16-bit address / 8-bit data memory port (ROM now, RAM later) between the CPU control unit and a debug monitor that reads memory for the 7-segment display. It runs fixed-priority arbitration with a starvation guard and sequences each access through an issue/wait/complete state machine. It also hides the memory read latency behind a req/done handshake. It sits between the requesters and the memory, on the CPU clock domain.

## Interface
- MEM_LATENCY, 0, cycles from the `mem_en` cycle to valid `mem_rdata`; legal 0..3 (0 = combinational ROM)
- STARVE_LIMIT, 8, consecutive denied monitor-request cycles before the monitor wins; legal 1..255
- clk_in  in  1  CPU clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cpu_req / mon_req  in  1  access request; hold until own `*_done`
- cpu_we / mon_we  in  1  1 = write, 0 = read
- cpu_addr / mon_addr  in  16  access address
- cpu_wdata / mon_wdata  in  8  write data
- cpu_gnt / mon_gnt  out  1  one-cycle pulse: request accepted
- cpu_done / mon_done  out  1  one-cycle pulse: access complete
- cpu_rdata / mon_rdata  out  8  read data, valid while own `*_done` = 1; held until the next own completion
- mem_en  out  1  one-cycle memory strobe
- mem_we  out  1  write qualifier for `mem_en`
- mem_addr  out  16  registered address
- mem_wdata  out  8  registered write data
- mem_rdata  in  8  memory read data
- busy  out  1  state ≠ IDLE
- owner  out  1  0 = CPU, 1 = monitor; holds the last grantee

## Operation
- States:
  - IDLE → ACCESS when any req = 1.
  - ACCESS → WAIT when MEM_LATENCY > 0, else → DONE.
  - WAIT → DONE after MEM_LATENCY cycles.
  - DONE → IDLE.
- IDLE arbitration:
  - CPU wins by default.
  - Monitor wins if it is the only requester, or if the starvation count equals STARVE_LIMIT.
  - Simultaneous requests with the count below the limit: CPU wins.
- On the IDLE→ACCESS edge, latch the winner's addr, wdata and we into the `mem_*` outputs; set `owner`; pulse that winner's `*_gnt`.
- ACCESS: `mem_en` = 1 for exactly one cycle; `mem_we` = latched we; `mem_addr` and `mem_wdata` stable from ACCESS through DONE.
- Read: sample `mem_rdata` at the end of the cycle MEM_LATENCY after ACCESS, into the owner's rdata register.
- Write: no rdata update; the owner's rdata keeps its old value.
- DONE: pulse the owner's `*_done`. Both read and write accesses complete this way.
- Requester protocol:
  - Drop req in the cycle after its `*_done`.
  - A req still high in IDLE starts a new access.
- Req dropped mid-access: the access still completes and done still pulses.
- Inputs are ignored outside IDLE. Addr/we/wdata changes after grant have no effect.
- Starvation counter, 8 bits:
  - +1 each cycle that mon_req = 1 and the monitor is not the current owner of an active access.
  - Saturates at STARVE_LIMIT.
  - Clears on monitor grant or when mon_req = 0.
- Reset (reset_n = 0 at an edge), from any state including mid-access:
  - State → IDLE; starvation counter → 0.
  - All outputs → 0: gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner.
  - The in-flight access is abandoned; no done is issued for it.

## Timing
- Request first seen high in IDLE at edge N:
  - Grant and ACCESS in cycle N+1.
  - `mem_rdata` sampled at the end of cycle N+1+MEM_LATENCY.
  - Done in cycle N+2+MEM_LATENCY.
  - IDLE in cycle N+3+MEM_LATENCY.
- Back-to-back throughput: one access per 3+MEM_LATENCY cycles.
- All outputs are registered; there is no combinational path from any input to any output.
- `busy` = 1 from the grant cycle through the DONE cycle.

## Structure
- Shared package `cpu_bus_pkg`:
  - state encoding: IDLE = 2'b00, ACCESS = 2'b01, WAIT = 2'b10, DONE = 2'b11
  - requester IDs: REQ_CPU = 0, REQ_MON = 1
  - address and data bus widths: 16 / 8
- One sub-module, `starve_timer`: the saturating counter with inc/clear/limit-reached outputs, reusable for later requesters.

## Test plan
- Reset, then CPU read of 16'h0001 with MEM_LATENCY = 0 and the ROM returning 8'hFF → `cpu_gnt` in cycle N+1, `cpu_done` in N+2, `cpu_rdata` = 8'hFF, `mon_*` outputs stay 0.
- MEM_LATENCY = 2, monitor write of 8'h5A to 16'h0010 → `mem_en` and `mem_we` = 1 for one cycle, `mem_addr` = 16'h0010 held through DONE, `mon_done` in N+4, `mon_rdata` unchanged.
- Both requests high continuously, STARVE_LIMIT = 4 → the CPU wins until the counter reaches 4, then the monitor is granted once, the counter clears, and the CPU wins again.
- reset_n pulled low during WAIT of a CPU read → next cycle is IDLE with every output 0, no `cpu_done` ever issued for that access, and a fresh request works normally.
- cpu_req dropped during ACCESS, and addr changed from 16'h0000 to 16'h0005 after grant → done still pulses, `mem_addr` stays 16'h0000, `cpu_rdata` = 8'hA0.
